// File: rtl/flexsoc_rst_seq.sv
// Reset sequencer: qualifies PLL/MMCM locks, then releases reset domains in index order.
// Optional lock-loss counter is enabled by defining RST_SEQ_LOSS_CNT_EN.
module flexsoc_rst_seq #(
    parameter int NUM_LOCK      = 2,
    parameter int NUM_OUT       = 3,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int STAGE_DELAY   = 16,
    parameter int SW_HOLD       = 8
) (
    input  logic                CLK,
    input  logic                RESETn,
    input  logic [NUM_LOCK-1:0] LOCKED,
    input  logic                SW_RST_REQ,
    output logic [NUM_OUT-1:0]  RSTn_OUT,
    output logic                READY,
    output logic                LOCK_LOST
`ifdef RST_SEQ_LOSS_CNT_EN
    ,
    output logic [7:0]          LOSS_CNT
`endif
);

    localparam int CNT_MAX_A = (STABLE_CYCLES > STAGE_DELAY) ? STABLE_CYCLES : STAGE_DELAY;
    localparam int CNT_MAX   = (CNT_MAX_A > SW_HOLD) ? CNT_MAX_A : SW_HOLD;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int STAGE_W   = $clog2(NUM_OUT + 1);

    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STAGE_LAST  = CNT_W'(STAGE_DELAY - 1);
    localparam logic [CNT_W-1:0]   HOLD_LAST   = CNT_W'(SW_HOLD - 1);
    localparam logic [STAGE_W-1:0] FINAL_STAGE = STAGE_W'(NUM_OUT - 1);

    typedef enum logic [2:0] {
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN,
        HOLD
    } state_e;

    state_e                               state_q, state_d;
    logic [CNT_W-1:0]                     cnt_q, cnt_d;
    logic [STAGE_W-1:0]                   stage_q, stage_d;
    logic [NUM_OUT-1:0]                   rstn_out_q, rstn_out_d;
    logic                                 ready_q, ready_d;
    logic                                 lock_lost_q, lock_lost_d;
    logic [SYNC_STAGES-1:0][NUM_LOCK-1:0] lock_sync_q, lock_sync_d;
    logic                                 all_locked;
    logic [CNT_W-1:0]                     cnt_inc;

    // Each LOCKED bit gets its own synchroniser chain; stage 0 sees the raw pin.
    always_comb begin
        lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], LOCKED};
    end

    assign all_locked = &lock_sync_q[SYNC_STAGES-1];
    assign cnt_inc    = cnt_q + CNT_W'(1);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d     = state_q;
        cnt_d       = '0;
        stage_d     = stage_q;
        rstn_out_d  = rstn_out_q;
        ready_d     = ready_q;
        lock_lost_d = 1'b0;

        unique case (state_q)
            WAIT_LOCK: begin
                if (all_locked) state_d = STABLE;
            end
            STABLE: begin
                if (!all_locked) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RELEASE;
                    stage_d = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RELEASE, RUN: begin
                // Lock loss outranks a simultaneous software request.
                if (!all_locked) begin
                    state_d     = WAIT_LOCK;
                    rstn_out_d  = '0;
                    ready_d     = 1'b0;
                    lock_lost_d = 1'b1;
                end else if (SW_RST_REQ) begin
                    state_d    = HOLD;
                    rstn_out_d = '0;
                    ready_d    = 1'b0;
                end else if (state_q == RELEASE) begin
                    if (cnt_q == STAGE_LAST) begin
                        for (int i = 0; i < NUM_OUT; i++) begin
                            if (stage_q == STAGE_W'(i)) rstn_out_d[i] = 1'b1;
                        end
                        stage_d = stage_q + STAGE_W'(1);
                        if (stage_q == FINAL_STAGE) begin
                            ready_d = 1'b1;
                            state_d = RUN;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            HOLD: begin
                rstn_out_d = '0;
                if (!all_locked) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = STABLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d    = WAIT_LOCK;
                rstn_out_d = '0;
                ready_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        // NOTE: registers update with <= so every flop samples pre-edge values of the others.
        if (!RESETn) begin
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            stage_q     <= '0;
            rstn_out_q  <= '0;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b0;
            // NOTE: the synchroniser chain is reset too, so locks must be re-seen after RESETn.
            lock_sync_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stage_q     <= stage_d;
            rstn_out_q  <= rstn_out_d;
            ready_q     <= ready_d;
            lock_lost_q <= lock_lost_d;
            lock_sync_q <= lock_sync_d;
        end
    end

    assign RSTn_OUT  = rstn_out_q;
    assign READY     = ready_q;
    assign LOCK_LOST = lock_lost_q;

`ifdef RST_SEQ_LOSS_CNT_EN
    logic [7:0] loss_cnt_q, loss_cnt_d;

    // Saturating count of LOCK_LOST pulses; only RESETn clears it.
    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (lock_lost_q && (loss_cnt_q != 8'hFF)) loss_cnt_d = loss_cnt_q + 8'd1;
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) loss_cnt_q <= 8'd0;
        else         loss_cnt_q <= loss_cnt_d;
    end

    assign LOSS_CNT = loss_cnt_q;
`endif

endmodule

// File: tb/tb_flexsoc_rst_seq.sv
// Self-checking bench for flexsoc_rst_seq: directed timing checks plus random lock/software
// disturbance compared every cycle against a phase/elapsed-time model.
module tb_flexsoc_rst_seq;

    localparam int NUM_LOCK      = 2;
    localparam int NUM_OUT       = 3;
    localparam int SYNC_STAGES   = 2;
    localparam int STABLE_CYCLES = 8;
    localparam int STAGE_DELAY   = 4;
    localparam int SW_HOLD       = 3;

    localparam int P_WAIT = 0;
    localparam int P_STAB = 1;
    localparam int P_SEQ  = 2;
    localparam int P_HOLD = 3;

    logic                CLK = 1'b0;
    logic                RESETn = 1'b1;
    logic [NUM_LOCK-1:0] LOCKED = '0;
    logic                SW_RST_REQ = 1'b0;
    logic [NUM_OUT-1:0]  RSTn_OUT;
    logic                READY;
    logic                LOCK_LOST;
`ifdef RST_SEQ_LOSS_CNT_EN
    logic [7:0]          LOSS_CNT;
`endif

    int total = 0;
    int bad   = 0;

    flexsoc_rst_seq #(
        .NUM_LOCK(NUM_LOCK), .NUM_OUT(NUM_OUT), .SYNC_STAGES(SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES), .STAGE_DELAY(STAGE_DELAY), .SW_HOLD(SW_HOLD)
    ) dut (
        .CLK(CLK),
        .RESETn(RESETn),
        .LOCKED(LOCKED),
        .SW_RST_REQ(SW_RST_REQ),
        .RSTn_OUT(RSTn_OUT),
        .READY(READY),
        .LOCK_LOST(LOCK_LOST)
`ifdef RST_SEQ_LOSS_CNT_EN
        ,
        .LOSS_CNT(LOSS_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the sequencer is in one of four phases; in the sequencing phase the number of
    // released domains is simply elapsed/STAGE_DELAY. Locks are seen SYNC_STAGES edges late.
    int ph       = P_WAIT;
    int elapsed  = 0;
    bit hist [SYNC_STAGES];
    bit m_lost   = 1'b0;
    int m_loss   = 0;

    function automatic int m_released();
        int r;
        if (ph != P_SEQ) return 0;
        r = elapsed / STAGE_DELAY;
        if (r > NUM_OUT) r = NUM_OUT;
        return r;
    endfunction

    function automatic logic [NUM_OUT-1:0] m_rstn();
        int v;
        v = (1 << m_released()) - 1;
        return v[NUM_OUT-1:0];
    endfunction

    task automatic model_reset();
        ph      = P_WAIT;
        elapsed = 0;
        m_lost  = 1'b0;
        m_loss  = 0;
        for (int i = 0; i < SYNC_STAGES; i++) hist[i] = 1'b0;
    endtask

    task automatic model_step();
        bit al;
        bit sw;
        al = hist[SYNC_STAGES-1];
        sw = SW_RST_REQ;
        if (m_lost && m_loss < 255) m_loss++;
        m_lost = 1'b0;
        if (ph == P_WAIT) begin
            if (al) begin ph = P_STAB; elapsed = 0; end
        end else if (ph == P_STAB) begin
            if (!al) begin ph = P_WAIT; elapsed = 0; end
            else if (elapsed == STABLE_CYCLES - 1) begin ph = P_SEQ; elapsed = 0; end
            else elapsed++;
        end else if (ph == P_SEQ) begin
            if (!al) begin ph = P_WAIT; elapsed = 0; m_lost = 1'b1; end
            else if (sw) begin ph = P_HOLD; elapsed = 0; end
            else if (elapsed < NUM_OUT * STAGE_DELAY) elapsed++;
        end else begin
            if (!al) begin ph = P_WAIT; elapsed = 0; end
            else if (elapsed == SW_HOLD - 1) begin ph = P_STAB; elapsed = 0; end
            else elapsed++;
        end
        for (int i = SYNC_STAGES - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = &LOCKED;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLK or negedge RESETn);
            if (!RESETn) model_reset();
            else         model_step();
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (RESETn) begin
                check("cmp_rstn", 32'(RSTn_OUT), 32'(m_rstn()));
                check("cmp_ready", 32'(READY), 32'(m_released() == NUM_OUT));
                check("cmp_lock_lost", 32'(LOCK_LOST), 32'(m_lost));
`ifdef RST_SEQ_LOSS_CNT_EN
                check("cmp_loss_cnt", 32'(LOSS_CNT), 32'(m_loss));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Locks were just raised; first domain must release on edge first_rel.
    task automatic expect_release(input string tag, input int first_rel);
        for (int n = 1; n <= first_rel + 2 * STAGE_DELAY; n++) begin
            tick();
            if (n == first_rel - 1) check({tag, "_pre"}, 32'(RSTn_OUT), 32'b000);
            if (n == first_rel)     check({tag, "_001"}, 32'(RSTn_OUT), 32'b001);
            if (n == first_rel + 4) check({tag, "_011"}, 32'(RSTn_OUT), 32'b011);
            if (n == first_rel + 7) check({tag, "_ready_lo"}, 32'(READY), 32'd0);
            if (n == first_rel + 8) begin
                check({tag, "_111"}, 32'(RSTn_OUT), 32'b111);
                check({tag, "_ready_hi"}, 32'(READY), 32'd1);
            end
        end
    endtask

    initial begin
        int drop_left;
        #1 RESETn = 1'b0;
        repeat (3) tick();
        check("rst_rstn", 32'(RSTn_OUT), 32'd0);
        check("rst_ready", 32'(READY), 32'd0);
        check("rst_lock_lost", 32'(LOCK_LOST), 32'd0);
        RESETn = 1'b1;
        repeat (2) tick();

        // Clean lock: STABLE at edge 3, releases at 15/19/23.
        LOCKED = 2'b11;
        expect_release("t1", 15);

        // Lock drop in RUN: outputs fall on the third edge after the pin.
        repeat (3) tick();
        LOCKED = 2'b10;
        for (int n = 1; n <= 4; n++) begin
            tick();
            if (n == 2) check("t3_still_run", 32'(RSTn_OUT), 32'b111);
            if (n == 3) begin
                check("t3_rstn", 32'(RSTn_OUT), 32'b000);
                check("t3_ready", 32'(READY), 32'd0);
                check("t3_lost_hi", 32'(LOCK_LOST), 32'd1);
            end
            if (n == 4) check("t3_lost_lo", 32'(LOCK_LOST), 32'd0);
        end
        LOCKED = 2'b11;
        expect_release("t3_relock", 15);

        // Software reset from RUN, with a second request during HOLD.
        SW_RST_REQ = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            tick();
            if (n == 2) SW_RST_REQ = 1'b0;
            if (n == 1)  check("t4_rstn_low", 32'(RSTn_OUT), 32'b000);
            if (n == 15) check("t4_pre", 32'(RSTn_OUT), 32'b000);
            if (n == 16) check("t4_001", 32'(RSTn_OUT), 32'b001);
            if (n == 20) check("t4_011", 32'(RSTn_OUT), 32'b011);
            if (n == 23) check("t4_ready_lo", 32'(READY), 32'd0);
            if (n == 24) begin
                check("t4_111", 32'(RSTn_OUT), 32'b111);
                check("t4_ready_hi", 32'(READY), 32'd1);
            end
        end

        // Software request coinciding with lock loss in RELEASE: lock loss wins.
        SW_RST_REQ = 1'b1;
        for (int n = 1; n <= 18; n++) begin
            tick();
            if (n == 1)  SW_RST_REQ = 1'b0;
            if (n == 14) LOCKED = 2'b00;
            if (n == 16) begin
                check("t5_001", 32'(RSTn_OUT), 32'b001);
                SW_RST_REQ = 1'b1;
            end
            if (n == 17) begin
                SW_RST_REQ = 1'b0;
                check("t5_rstn", 32'(RSTn_OUT), 32'b000);
                check("t5_lost_hi", 32'(LOCK_LOST), 32'd1);
            end
            if (n == 18) check("t5_lost_lo", 32'(LOCK_LOST), 32'd0);
        end

        // One-cycle glitch during STABLE restarts the full stability window.
        LOCKED = 2'b11;
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (n == 6) LOCKED = 2'b01;
            if (n == 7) LOCKED = 2'b11;
            if (n < 22) begin
                check("t2_rstn_held", 32'(RSTn_OUT), 32'b000);
                check("t2_no_lost", 32'(LOCK_LOST), 32'd0);
            end
            if (n == 22) check("t2_001", 32'(RSTn_OUT), 32'b001);
            if (n == 30) begin
                check("t2_111", 32'(RSTn_OUT), 32'b111);
                check("t2_ready", 32'(READY), 32'd1);
            end
        end

        // Random lock glitches and software requests.
        drop_left = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (drop_left > 0) begin
                drop_left--;
                if (drop_left == 0) LOCKED = 2'b11;
            end else if ($urandom_range(0, 149) == 0) begin
                LOCKED = 2'($urandom_range(0, 2));
                drop_left = $urandom_range(1, 4);
            end
            SW_RST_REQ = ($urandom_range(0, 29) == 0);
        end
        SW_RST_REQ = 1'b0;

        // Asynchronous reset in the middle of RELEASE.
        LOCKED = 2'b00;
        repeat (4) tick();
        LOCKED = 2'b11;
        repeat (16) tick();
        check("t6_mid_release", 32'(RSTn_OUT), 32'b001);
        #2 RESETn = 1'b0;
        #1;
        check("t6_rstn_async", 32'(RSTn_OUT), 32'd0);
        check("t6_ready_async", 32'(READY), 32'd0);
        check("t6_lost_async", 32'(LOCK_LOST), 32'd0);
        repeat (2) tick();
        RESETn = 1'b1;
        repeat (2) tick();
        check("t6_after_rst", 32'(RSTn_OUT), 32'd0);

`ifdef RST_SEQ_LOSS_CNT_EN
        for (int k = 0; k < 300; k++) begin
            LOCKED = 2'b11;
            repeat (11) tick();
            LOCKED = 2'b00;
            repeat (4) tick();
        end
        check("t6_loss_sat", 32'(LOSS_CNT), 32'd255);
        RESETn = 1'b0;
        #1;
        check("t6_loss_clr", 32'(LOSS_CNT), 32'd0);
        tick();
        RESETn = 1'b1;
        repeat (2) tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
